// File: rtl/apb_uart_master.sv
// apb_uart_master
// Turns a valid/ready command into one APB3 transfer towards the UART slave
// and hands back read data plus a timeout flag on a valid/ready response.
//
// state  | meaning
// -------+------------------------------------------------------------
// IDLE   | waiting for a command; req_ready high
// SETUP  | APB setup phase (PSEL=1, PENABLE=0), exactly one cycle
// ACCESS | APB access phase, waiting for PREADY or the timeout
// RESP   | response held on rsp_* until rsp_ready
module apb_uart_master #(
    parameter int TIMEOUT = 16,
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32
) (
    input  logic              PCLK,
    input  logic              PRESETn,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic [ADDR_W-1:0] PADDR,
    output logic              PSEL,
    output logic              PENABLE,
    output logic              PWRITE,
    output logic [DATA_W-1:0] PWDATA,
    input  logic [DATA_W-1:0] PRDATA,
    input  logic              PREADY
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_SETUP  = 2'd1;
    localparam logic [1:0] S_ACCESS = 2'd2;
    localparam logic [1:0] S_RESP   = 2'd3;

    // A zero TIMEOUT still needs a 1-bit counter to keep the logic legal.
    localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam logic             TO_EN    = (TIMEOUT != 0);

    logic [1:0]        state_q, state_d;
    logic              psel_q, psel_d;
    logic              penable_q, penable_d;
    logic              pwrite_q, pwrite_d;
    logic [ADDR_W-1:0] paddr_q, paddr_d;
    logic [DATA_W-1:0] pwdata_q, pwdata_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
    logic              rsp_err_q, rsp_err_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              timeout_hit;

    // The cycle that would take the counter to TIMEOUT is the last one allowed.
    assign timeout_hit = TO_EN && (cnt_q == CNT_LAST);

    // Next-state and output register computation for the transfer FSM.
    always_comb begin
        state_d     = state_q;
        psel_d      = psel_q;
        penable_d   = penable_q;
        pwrite_d    = pwrite_q;
        paddr_d     = paddr_q;
        pwdata_d    = pwdata_q;
        rsp_valid_d = rsp_valid_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        cnt_d       = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    paddr_d   = req_addr;
                    pwrite_d  = req_write;
                    pwdata_d  = req_wdata;
                    psel_d    = 1'b1;
                    penable_d = 1'b0;
                    state_d   = S_SETUP;
                end
            end
            S_SETUP: begin
                penable_d = 1'b1;
                cnt_d     = '0;
                state_d   = S_ACCESS;
            end
            S_ACCESS: begin
                if (PREADY) begin
                    // A completion in the same cycle as the timeout still wins.
                    psel_d      = 1'b0;
                    penable_d   = 1'b0;
                    rsp_rdata_d = pwrite_q ? '0 : PRDATA;
                    rsp_err_d   = 1'b0;
                    rsp_valid_d = 1'b1;
                    state_d     = S_RESP;
                end else begin
                    if (cnt_q != CNT_MAX) begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                    if (timeout_hit) begin
                        psel_d      = 1'b0;
                        penable_d   = 1'b0;
                        rsp_rdata_d = '0;
                        rsp_err_d   = 1'b1;
                        rsp_valid_d = 1'b1;
                        state_d     = S_RESP;
                    end
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers; reset clears the bus strobes immediately.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_q     <= S_IDLE;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            pwrite_q    <= 1'b0;
            paddr_q     <= '0;
            pwdata_q    <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            psel_q      <= psel_d;
            penable_q   <= penable_d;
            pwrite_q    <= pwrite_d;
            paddr_q     <= paddr_d;
            pwdata_q    <= pwdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
            cnt_q       <= cnt_d;
        end
    end

    assign req_ready = (state_q == S_IDLE);
    assign PSEL      = psel_q;
    assign PENABLE   = penable_q;
    assign PWRITE    = pwrite_q;
    assign PADDR     = paddr_q;
    assign PWDATA    = pwdata_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_apb_uart_master.sv
// Bench for apb_uart_master: a UART-like APB slave with programmable wait
// states, a TIMEOUT=0 instance against a never-ready slave, and a reference
// model of the register contents and expected response for each transfer.
module tb_apb_uart_master;

    localparam int TO = 16;

    logic        PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    logic        PRESETn;
    logic        srst_b;
    logic        req_valid, req_ready, req_write;
    logic [31:0] req_addr, req_wdata;
    logic        rsp_valid, rsp_ready, rsp_err;
    logic [31:0] rsp_rdata;
    logic [31:0] PADDR, PWDATA, PRDATA;
    logic        PSEL, PENABLE, PWRITE, PREADY;

    apb_uart_master #(.TIMEOUT(TO), .ADDR_W(32), .DATA_W(32)) dut (
        .PCLK(PCLK), .PRESETn(PRESETn),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err),
        .PADDR(PADDR), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
        .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY)
    );

    // second instance: timeout disabled, slave never ready
    logic        req_valid_z, req_ready_z, rsp_valid_z, rsp_err_z;
    logic [31:0] rsp_rdata_z, PADDR_z, PWDATA_z;
    logic        PSEL_z, PENABLE_z, PWRITE_z;
    logic [31:0] prdata_z = 32'h0;
    logic        pready_z = 1'b0;
    logic        rsp_ready_z = 1'b1;
    logic        req_write_z = 1'b1;
    logic [31:0] req_addr_z = 32'h40;
    logic [31:0] req_wdata_z = 32'h1357_9BDF;

    apb_uart_master #(.TIMEOUT(0), .ADDR_W(32), .DATA_W(32)) dut_z (
        .PCLK(PCLK), .PRESETn(PRESETn),
        .req_valid(req_valid_z), .req_ready(req_ready_z), .req_write(req_write_z),
        .req_addr(req_addr_z), .req_wdata(req_wdata_z),
        .rsp_valid(rsp_valid_z), .rsp_ready(rsp_ready_z), .rsp_rdata(rsp_rdata_z),
        .rsp_err(rsp_err_z),
        .PADDR(PADDR_z), .PSEL(PSEL_z), .PENABLE(PENABLE_z), .PWRITE(PWRITE_z),
        .PWDATA(PWDATA_z), .PRDATA(prdata_z), .PREADY(pready_z)
    );

    // ---------------- slave stand-in ----------------
    logic        tie_one, stub_mode;
    int          wait_n;
    int          acc_cnt;
    logic [31:0] smem [4];
    logic [31:0] stub_q;

    assign PREADY = tie_one ? 1'b1 : (PSEL && PENABLE && (acc_cnt == wait_n));
    assign PRDATA = stub_mode ? stub_q :
                    ((PADDR[1:0] == 2'b00 && PADDR < 32'd16) ? smem[PADDR[3:2]] : 32'h0);

    always @(posedge PCLK) begin
        if (!srst_b) begin
            acc_cnt <= 0;
            stub_q  <= 32'hC0DE_0000;
            for (int i = 0; i < 4; i++) smem[i] <= 32'h0;
        end else begin
            if (PSEL && PENABLE && !PREADY) acc_cnt <= acc_cnt + 1;
            else if (!(PSEL && PENABLE))    acc_cnt <= 0;
            if (PSEL && PENABLE && PREADY) begin
                stub_q <= stub_q + 32'd1;
                if (PWRITE && PADDR[1:0] == 2'b00 && PADDR < 32'd16)
                    smem[PADDR[3:2]] <= PWDATA;
            end
        end
    end

    // ---------------- reference model ----------------
    logic [31:0] mdl_mem [4];

    function automatic logic mdl_mapped(input logic [31:0] a);
        return (a[1:0] == 2'b00) && (a < 32'd16);
    endfunction

    function automatic logic [31:0] mdl_read(input logic [31:0] a);
        return mdl_mapped(a) ? mdl_mem[a[3:2]] : 32'h0;
    endfunction

    // ---------------- checking ----------------
    int n_chk = 0;
    int n_err = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // One transfer; returns once rsp_valid is seen (response not consumed here).
    task automatic xfer(input logic wr, input logic [31:0] a, input logic [31:0] d,
                        output logic [31:0] rd, output logic er,
                        output int n_sel, output int n_en, output logic stable);
        int k;
        @(negedge PCLK);
        req_valid = 1'b1; req_write = wr; req_addr = a; req_wdata = d;
        k = 0;
        while (!req_ready && k < 100) begin @(negedge PCLK); k++; end
        @(posedge PCLK); #1;
        req_valid = 1'b0;
        n_sel = 0; n_en = 0; stable = 1'b1; k = 0;
        @(negedge PCLK);
        while (!rsp_valid && k < 2000) begin
            if (PSEL) begin
                n_sel++;
                if (PADDR !== a || PWRITE !== wr || PWDATA !== d) stable = 1'b0;
            end
            if (PENABLE) n_en++;
            @(negedge PCLK);
            k++;
        end
        n_chk++;
        if (!rsp_valid) begin
            n_err++;
            $display("FAIL rsp_wait: got no rsp_valid expected one within 2000 cycles");
        end
        rd = rsp_rdata;
        er = rsp_err;
    endtask

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          wt;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    vec_t        vecs [10];
    logic [31:0] rd, hold_rd, base;
    logic        er, stb, wr_r;
    int          ns, ne, bad, k, exp_en;
    logic [31:0] a_r, d_r;
    logic [31:0] addr_pool [6];

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish expected end of test");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{1'b1, 32'h0,  32'h0000_0005, 1,  32'h0,         1'b0};
        vecs[1] = '{1'b0, 32'h0,  32'h0,         1,  32'h0000_0005, 1'b0};
        vecs[2] = '{1'b0, 32'h7,  32'h0,         1,  32'h0,         1'b0};
        vecs[3] = '{1'b1, 32'h4,  32'hDEAD_BEEF, 0,  32'h0,         1'b0};
        vecs[4] = '{1'b0, 32'h4,  32'h0,         3,  32'hDEAD_BEEF, 1'b0};
        vecs[5] = '{1'b0, 32'h4,  32'h0,         16, 32'h0,         1'b1};
        vecs[6] = '{1'b1, 32'h8,  32'h0000_1234, 15, 32'h0,         1'b0};
        vecs[7] = '{1'b0, 32'h8,  32'h0,         0,  32'h0000_1234, 1'b0};
        vecs[8] = '{1'b1, 32'h0,  32'h0000_0077, 16, 32'h0,         1'b1};
        vecs[9] = '{1'b0, 32'h0,  32'h0,         2,  32'h0000_0005, 1'b0};
        addr_pool[0] = 32'h0; addr_pool[1] = 32'h4; addr_pool[2] = 32'h8;
        addr_pool[3] = 32'hC; addr_pool[4] = 32'h7; addr_pool[5] = 32'h10;
        for (int i = 0; i < 4; i++) mdl_mem[i] = 32'h0;

        PRESETn = 1'b0; srst_b = 1'b0;
        req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
        rsp_ready = 1'b1; req_valid_z = 1'b0;
        tie_one = 1'b0; stub_mode = 1'b0; wait_n = 1;
        #1;
        check("reset_psel_penable_rspv", {29'b0, PSEL, PENABLE, rsp_valid}, 32'h0);
        check("reset_req_ready", {31'b0, req_ready}, 32'h1);
        check("reset_paddr", PADDR, 32'h0);
        @(posedge PCLK); @(posedge PCLK);
        @(negedge PCLK); PRESETn = 1'b1; srst_b = 1'b1;

        // table-driven transfers against the UART-like slave
        for (int i = 0; i < 10; i++) begin
            wait_n = vecs[i].wt;
            exp_en = (vecs[i].wt >= TO) ? TO : vecs[i].wt + 1;
            xfer(vecs[i].wr, vecs[i].addr, vecs[i].wdata, rd, er, ns, ne, stb);
            check($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rdata);
            check($sformatf("vec%0d_err", i), {31'b0, er}, {31'b0, vecs[i].exp_err});
            check($sformatf("vec%0d_penable_cycles", i), ne, exp_en);
            check($sformatf("vec%0d_psel_cycles", i), ns, exp_en + 1);
            check($sformatf("vec%0d_bus_stable", i), {31'b0, stb}, 32'h1);
            @(negedge PCLK);
            check($sformatf("vec%0d_rsp_one_cycle", i), {30'b0, rsp_valid, PSEL}, 32'h0);
            if (vecs[i].wr && !vecs[i].exp_err && mdl_mapped(vecs[i].addr))
                mdl_mem[vecs[i].addr[3:2]] = vecs[i].wdata;
        end

        // randomized transfers checked against the model
        for (int i = 0; i < 30; i++) begin
            wr_r = 1'($urandom_range(0, 1));
            a_r  = addr_pool[$urandom_range(0, 5)];
            d_r  = $urandom;
            k    = $urandom_range(0, 9);
            wait_n = (k == 9) ? 16 + $urandom_range(0, 3) : k % 4;
            exp_en = (wait_n >= TO) ? TO : wait_n + 1;
            xfer(wr_r, a_r, d_r, rd, er, ns, ne, stb);
            check($sformatf("rnd%0d_err", i), {31'b0, er}, {31'b0, wait_n >= TO});
            check($sformatf("rnd%0d_rdata", i), rd,
                  (wait_n >= TO || wr_r) ? 32'h0 : mdl_read(a_r));
            check($sformatf("rnd%0d_penable_cycles", i), ne, exp_en);
            check($sformatf("rnd%0d_bus_stable", i), {31'b0, stb}, 32'h1);
            if (wr_r && wait_n < TO && mdl_mapped(a_r)) mdl_mem[a_r[3:2]] = d_r;
        end

        // response backpressure with a new command waiting
        wait_n = 1;
        @(negedge PCLK); rsp_ready = 1'b0;
        xfer(1'b0, 32'h0, 32'h0, rd, er, ns, ne, stb);
        check("bp_rdata", rd, mdl_read(32'h0));
        hold_rd = rd;
        req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h4; req_wdata = 32'h0;
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge PCLK);
            if (!rsp_valid || rsp_rdata !== hold_rd || req_ready || PSEL) bad++;
        end
        check("bp_hold_cycles_bad", bad, 0);
        rsp_ready = 1'b1;
        k = 0;
        do begin @(negedge PCLK); k++; end while (!PSEL && k < 10);
        check("bp_setup_delay", k, 2);
        req_valid = 1'b0;
        k = 0;
        while (!rsp_valid && k < 100) begin @(negedge PCLK); k++; end
        check("bp_second_rdata", rsp_rdata, mdl_read(32'h4));
        @(negedge PCLK);

        // reset during the second ACCESS cycle
        wait_n = 5;
        req_valid = 1'b1; req_write = 1'b1; req_addr = 32'hC; req_wdata = 32'hFFFF_0000;
        @(posedge PCLK); #1 req_valid = 1'b0;
        @(negedge PCLK); @(negedge PCLK); @(negedge PCLK);
        check("rst_mid_in_access", {30'b0, PSEL, PENABLE}, 32'h3);
        #2 PRESETn = 1'b0;
        #1;
        check("rst_mid_strobes", {29'b0, PSEL, PENABLE, rsp_valid}, 32'h0);
        @(negedge PCLK); PRESETn = 1'b1;
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge PCLK);
            if (rsp_valid || PSEL) bad++;
        end
        check("rst_mid_no_rsp", bad, 0);
        wait_n = 1;
        xfer(1'b1, 32'h2, 32'h0000_00A5, rd, er, ns, ne, stb);
        check("post_rst_err", {31'b0, er}, 32'h0);
        check("post_rst_rdata", rd, 32'h0);
        check("post_rst_penable_cycles", ne, 2);
        @(negedge PCLK);

        // zero-wait stub: PREADY tied high, PRDATA counts completed transfers
        tie_one = 1'b1; stub_mode = 1'b1;
        @(negedge PCLK);
        base = stub_q;
        for (int i = 0; i < 4; i++) begin
            xfer(1'b0, 32'h8, 32'h0, rd, er, ns, ne, stb);
            check($sformatf("zw%0d_rdata", i), rd, base + 32'(i));
            check($sformatf("zw%0d_err", i), {31'b0, er}, 32'h0);
            check($sformatf("zw%0d_psel_cycles", i), ns, 2);
            check($sformatf("zw%0d_penable_cycles", i), ne, 1);
        end
        @(negedge PCLK);
        tie_one = 1'b0; stub_mode = 1'b0;

        // TIMEOUT=0 instance against a never-ready slave
        req_valid_z = 1'b1;
        @(posedge PCLK); #1 req_valid_z = 1'b0;
        bad = 0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge PCLK);
            if (rsp_valid_z) bad++;
        end
        check("to0_no_rsp", bad, 0);
        check("to0_strobes", {29'b0, PSEL_z, PENABLE_z, req_ready_z}, 32'h6);
        check("to0_paddr", PADDR_z, 32'h40);
        check("to0_pwdata", PWDATA_z, 32'h1357_9BDF);
        check("to0_pwrite_err", {30'b0, PWRITE_z, rsp_err_z}, 32'h2);
        check("to0_rdata", rsp_rdata_z, 32'h0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
